// File: rtl/pwm_from_count.sv
`default_nettype none
// ============================================================================
// Module      : pwm_from_count
// Description : PWM generator driven by an upstream free-running count, with
//               wrap-aligned double-buffered duty and count-sequence monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_from_count #(
    parameter int WIDTH      = 4,
    parameter int RESET_DUTY = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH:0]   duty_in,
    input  logic             duty_load,
    output logic             duty_pending,
    output logic             duty_ack,
    output logic             pwm_out,
    output logic             period_pulse,
    output logic             seq_err
);

    localparam logic [0:0]     c_state_sync = 1'b0;
    localparam logic [0:0]     c_state_run  = 1'b1;
    localparam logic [WIDTH:0] c_full_duty  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] c_reset_duty = (WIDTH+1)'(RESET_DUTY);

    logic [0:0]       r_state;
    logic [WIDTH:0]   r_active_duty;
    logic [WIDTH:0]   r_pend_duty;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_prev_count;
    logic             r_pwm;
    logic             r_period_pulse;
    logic             r_duty_ack;
    logic             r_seq_err;

    logic [WIDTH:0]   w_sat_duty;
    logic             w_is_zero;
    logic             w_in_run;
    logic             w_seq_bad;
    logic [WIDTH:0]   w_eff_duty;
    logic [WIDTH-1:0] w_expected_count;

    assign w_sat_duty       = (duty_in > c_full_duty) ? c_full_duty : duty_in;
    assign w_is_zero        = (count_in == '0);
    assign w_in_run         = (r_state == c_state_run);
    assign w_expected_count = r_prev_count + WIDTH'(1);
    // A broken step takes priority over a wrap, so a bad jump onto 0 resyncs.
    assign w_seq_bad        = w_in_run && (count_in != w_expected_count);

    always_comb begin
        w_eff_duty = r_active_duty;
        if (w_is_zero && !w_seq_bad) begin
            if (duty_load) begin
                w_eff_duty = w_sat_duty;
            end else if (r_pend_valid) begin
                w_eff_duty = r_pend_duty;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= c_state_sync;
            r_active_duty  <= c_reset_duty;
            r_pend_duty    <= '0;
            r_pend_valid   <= 1'b0;
            r_prev_count   <= '0;
            r_pwm          <= 1'b0;
            r_period_pulse <= 1'b0;
            r_duty_ack     <= 1'b0;
            r_seq_err      <= 1'b0;
        end else begin
            r_prev_count   <= count_in;
            r_period_pulse <= 1'b0;
            r_duty_ack     <= 1'b0;
            if (w_seq_bad) begin
                r_seq_err <= 1'b1;
                r_state   <= c_state_sync;
                r_pwm     <= 1'b0;
                if (duty_load) begin
                    r_pend_duty  <= w_sat_duty;
                    r_pend_valid <= 1'b1;
                end
            end else if (w_is_zero) begin
                r_state        <= c_state_run;
                r_active_duty  <= w_eff_duty;
                r_pend_valid   <= 1'b0;
                r_duty_ack     <= duty_load | r_pend_valid;
                r_period_pulse <= w_in_run;
                r_pwm          <= ({1'b0, count_in} < w_eff_duty);
            end else begin
                if (duty_load) begin
                    r_pend_duty  <= w_sat_duty;
                    r_pend_valid <= 1'b1;
                end
                r_pwm <= w_in_run && ({1'b0, count_in} < r_active_duty);
            end
        end
    end

    assign duty_pending = r_pend_valid;
    assign duty_ack     = r_duty_ack;
    assign pwm_out      = r_pwm;
    assign period_pulse = r_period_pulse;
    assign seq_err      = r_seq_err;

endmodule
`default_nettype wire
